// File: rtl/mod_74xx_pkg.sv
// mod_74xx_pkg: shared slice constants and width helpers for the 74xx counter family
package mod_74xx_pkg;

    localparam int SLICE_W = 4;
    localparam logic [SLICE_W-1:0] SLICE_MAX = 4'hF;

    function automatic int n_slices(input int width);
        return width / SLICE_W;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= SLICE_W) && (width % SLICE_W == 0);
    endfunction

endpackage

// File: rtl/mod_74x161_slice.sv
// mod_74x161_slice: one 4-bit 74x161-style counter slice (74x191-style up/down with MOD_74X161_UPDOWN_EN)
// Ports: CLK clock, RST async active-high reset to RESET_VAL, LOAD_N sync load of D,
//        ENP/ENT count enables, DN direction (MOD_74X161_UPDOWN_EN only),
//        Q slice value, RCO terminal-count carry/borrow gated by ENT.
module mod_74x161_slice
    import mod_74xx_pkg::*;
#(
    parameter logic [SLICE_W-1:0] RESET_VAL = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               LOAD_N,
    input  logic [SLICE_W-1:0] D,
    input  logic               ENP,
    input  logic               ENT,
`ifdef MOD_74X161_UPDOWN_EN
    input  logic               DN,
`endif
    output logic [SLICE_W-1:0] Q,
    output logic               RCO
);

    logic               dn;
    logic [SLICE_W-1:0] cnt_d, cnt_q;

`ifdef MOD_74X161_UPDOWN_EN
    assign dn = DN;
`else
    assign dn = 1'b0;
`endif

    // load outranks counting and ignores the enables
    always_comb begin
        cnt_d = !LOAD_N ? D :
                (ENP && ENT) ? (dn ? cnt_q - 4'd1 : cnt_q + 4'd1) : cnt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= RESET_VAL;
        else     cnt_q <= cnt_d;
    end

    // terminal count is all-ones going up, zero going down; ENP plays no part
    assign RCO = ENT && (dn ? (cnt_q == '0) : (cnt_q == SLICE_MAX));
    assign Q   = cnt_q;

endmodule

// File: rtl/mod_74x161_cascade.sv
// mod_74x161_cascade: WIDTH-bit counter built from chained 4-bit 74x161-style slices
// Ports: CLK clock, RST async active-high reset to RESET_VAL, LOAD_N sync load of D,
//        ENP parallel enable, ENT trickle enable, DN direction (MOD_74X161_UPDOWN_EN only),
//        Q counter value, RCO combinational ripple carry of the last slice.
// Optional feature macro: MOD_74X161_UPDOWN_EN adds DN and down counting.
module mod_74x161_cascade
    import mod_74xx_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_N,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
`ifdef MOD_74X161_UPDOWN_EN
    input  logic             DN,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam int N = n_slices(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("mod_74x161_cascade: WIDTH must be a multiple of 4 and at least 4");
    end

    // ent_c[k] is the trickle enable into slice k; the last entry is the block carry
    logic [N:0] ent_c;

    assign ent_c[0] = ENT;

    for (genvar k = 0; k < N; k++) begin : g_slice
        mod_74x161_slice #(
            .RESET_VAL(RESET_VAL[SLICE_W*k +: SLICE_W])
        ) u_slice (
            .CLK   (CLK),
            .RST   (RST),
            .LOAD_N(LOAD_N),
            .D     (D[SLICE_W*k +: SLICE_W]),
            .ENP   (ENP),
            .ENT   (ent_c[k]),
`ifdef MOD_74X161_UPDOWN_EN
            .DN    (DN),
`endif
            .Q     (Q[SLICE_W*k +: SLICE_W]),
            .RCO   (ent_c[k+1])
        );
    end

    assign RCO = ent_c[N];

endmodule

// File: tb/tb_mod_74x161_cascade.sv
// tb_mod_74x161_cascade: directed and random checks of 8- and 12-bit cascades against an arithmetic model
module tb_mod_74x161_cascade;

    localparam logic [7:0]  RV8  = 8'h5A;
    localparam logic [11:0] RV12 = 12'hA5C;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        LOAD_N = 1'b1;
    logic        ENP = 1'b0;
    logic        ENT = 1'b0;
    logic        DN = 1'b0;
    logic [11:0] D12 = '0;
    logic [7:0]  D8;
    logic [7:0]  Q8;
    logic [11:0] Q12;
    logic        RCO8, RCO12;

    int n_chk = 0;
    int n_fail = 0;
    int m8, m12;

    assign D8 = D12[7:0];

    always #5 CLK = ~CLK;

    mod_74x161_cascade #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
        .CLK(CLK), .RST(RST), .LOAD_N(LOAD_N), .D(D8), .ENP(ENP), .ENT(ENT),
`ifdef MOD_74X161_UPDOWN_EN
        .DN(DN),
`endif
        .Q(Q8), .RCO(RCO8)
    );

    mod_74x161_cascade #(.WIDTH(12), .RESET_VAL(RV12)) dut12 (
        .CLK(CLK), .RST(RST), .LOAD_N(LOAD_N), .D(D12), .ENP(ENP), .ENT(ENT),
`ifdef MOD_74X161_UPDOWN_EN
        .DN(DN),
`endif
        .Q(Q12), .RCO(RCO12)
    );

    function automatic int nxt(input int m, input int mask, input int d);
        if (!LOAD_N) return d & mask;
        if (ENP && ENT) return DN ? (m - 1) & mask : (m + 1) & mask;
        return m;
    endfunction

    function automatic logic exp_rco(input int m, input int mask);
        return ENT && (DN ? (m == 0) : (m == mask));
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        check({tag, " q8"}, {4'h0, Q8}, 12'(m8));
        check({tag, " q12"}, Q12, 12'(m12));
        check({tag, " rco8"}, {11'h0, RCO8}, {11'h0, exp_rco(m8, 255)});
        check({tag, " rco12"}, {11'h0, RCO12}, {11'h0, exp_rco(m12, 4095)});
    endtask

    task automatic step(input string tag);
        int n8, n12;
        n8  = nxt(m8, 255, int'(D8));
        n12 = nxt(m12, 4095, int'(D12));
        @(posedge CLK);
        #1;
        m8  = n8;
        m12 = n12;
        chk_all(tag);
    endtask

    initial begin
        #2;
        RST = 1'b1;
        m8 = int'(RV8);
        m12 = int'(RV12);
        #1;
        chk_all("reset_async");
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) step("hold_after_reset");

        D12 = 12'hFFD;
        LOAD_N = 1'b0;
        step("load_fd");
        LOAD_N = 1'b1;
        ENP = 1'b1;
        ENT = 1'b1;
        for (int i = 0; i < 4; i++) step("count_wrap");

        D12 = 12'h00F;
        LOAD_N = 1'b0;
        step("load_0f");
        LOAD_N = 1'b1;
        ENP = 1'b0;
        step("enp_low_hold");
        D12 = 12'hFFF;
        LOAD_N = 1'b0;
        step("load_ff");
        LOAD_N = 1'b1;
        ENP = 1'b1;
        ENT = 1'b0;
        #1;
        chk_all("ent_low_rco");
        step("ent_low_hold");

        D12 = 12'h033;
        LOAD_N = 1'b0;
        ENT = 1'b1;
        step("load_priority");

        D12 = 12'h7FE;
        step("load_7fe");
        LOAD_N = 1'b1;
        step("count_7ff");
        #2;
        RST = 1'b1;
        m8 = int'(RV8);
        m12 = int'(RV12);
        #1;
        chk_all("reset_mid_count");
        @(posedge CLK);
        RST <= 1'b0;
        #1;
        chk_all("release_on_edge");
        step("count_after_release");

`ifdef MOD_74X161_UPDOWN_EN
        D12 = 12'h001;
        LOAD_N = 1'b0;
        step("load_01");
        LOAD_N = 1'b1;
        DN = 1'b1;
        for (int i = 0; i < 3; i++) step("count_down");
`endif

        for (int i = 0; i < 300; i++) begin
            D12    = 12'($urandom);
            LOAD_N = ($urandom_range(0, 7) != 0);
            ENP    = ($urandom_range(0, 3) != 0);
            ENT    = ($urandom_range(0, 3) != 0);
`ifdef MOD_74X161_UPDOWN_EN
            DN     = 1'($urandom);
`endif
            #1;
            chk_all("rand_comb");
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
